// File: rtl/alu_cc_unit_if.sv
// Bundle of the E-stage signals that feed the condition-code unit and its
// readback outputs. The master side is the pipeline control/ALU and the
// slave side is alu_cc_unit. CNT_W must match the unit's CNT_W.
interface alu_cc_unit_if #(
   parameter int CNT_W = 16
);
   logic             set_cc;
   logic             stall;
   logic             exc_block;
   logic [3:0]       alu_fn;
   logic [63:0]      alu_result;
   logic             alu_ovf;
   logic [3:0]       cond_fn;
   logic [2:0]       cc_out;
   logic             cond_out;
   logic             fn_err;
   logic [CNT_W-1:0] cc_updates;

   modport master (
      output set_cc, stall, exc_block, alu_fn, alu_result, alu_ovf, cond_fn,
      input  cc_out, cond_out, fn_err, cc_updates
   );

   modport slave (
      input  set_cc, stall, exc_block, alu_fn, alu_result, alu_ovf, cond_fn,
      output cc_out, cond_out, fn_err, cc_updates
   );
endinterface

// File: rtl/alu_cc_unit.sv
// Y86-64 execute-stage condition-code register and jXX/cmovXX condition
// evaluator. Flags are {ZF,SF,OF}, written one cycle after a committed OPq.
// A sticky error flag records illegal ALU or condition function codes, and a
// saturating counter tracks committed flag writes.
// Optional macro ALU_CC_BYPASS_EN: when defined, cond_out is evaluated on the
// flags being written in the same cycle, so a fused compare-branch sees its
// own result before the register updates.
module alu_cc_unit #(
   parameter int CNT_W = 16
) (
   input  logic         clk,
   input  logic         reset,
   alu_cc_unit_if.slave bus
);

   localparam logic [2:0]       CC_RESET = 3'b100;
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   // Condition evaluation on flags ordered {ZF,SF,OF}; unknown codes give 0.
   function automatic logic eval_cond(input logic [3:0] fn, input logic [2:0] f);
      logic zf;
      logic sf;
      logic of;
      logic res;
      zf = f[2];
      sf = f[1];
      of = f[0];
      case (fn)
         4'd0:    res = 1'b1;
         4'd1:    res = (sf ^ of) | zf;
         4'd2:    res = sf ^ of;
         4'd3:    res = zf;
         4'd4:    res = ~zf;
         4'd5:    res = ~(sf ^ of);
         4'd6:    res = ~(sf ^ of) & ~zf;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   logic [2:0]       cc_q;
   logic [2:0]       cc_d;
   logic             fn_err_q;
   logic             fn_err_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   logic             alu_fn_legal_s;
   logic             cond_fn_legal_s;
   logic             we_s;
   logic             of_new_s;
   logic [2:0]       flags_new_s;
   logic [2:0]       flags_eff_s;

   // Decode function-code legality and the commit strobe for this cycle.
   always_comb begin
      alu_fn_legal_s  = (bus.alu_fn <= 4'd3);
      cond_fn_legal_s = (bus.cond_fn <= 4'd6);
      we_s            = bus.set_cc & ~bus.stall & ~bus.exc_block & alu_fn_legal_s;
   end

   // New flags from the ALU result; logic ops never report overflow.
   always_comb begin
      case (bus.alu_fn)
         4'd0, 4'd1: of_new_s = bus.alu_ovf;
         default:    of_new_s = 1'b0;
      endcase
      flags_new_s = {(bus.alu_result == 64'd0), bus.alu_result[63], of_new_s};
   end

   // Select the flags the condition is evaluated on.
   always_comb begin
`ifdef ALU_CC_BYPASS_EN
      if (we_s) begin
         flags_eff_s = flags_new_s;
      end else begin
         flags_eff_s = cc_q;
      end
`else
      flags_eff_s = cc_q;
`endif
   end

   // Next-state for flags, sticky error and saturating update counter.
   always_comb begin
      if (we_s) begin
         cc_d = flags_new_s;
      end else begin
         cc_d = cc_q;
      end

      if (~bus.stall & ((bus.set_cc & ~alu_fn_legal_s) | ~cond_fn_legal_s)) begin
         fn_err_d = 1'b1;
      end else begin
         fn_err_d = fn_err_q;
      end

      if (we_s && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State registers; reset wins over any pending write.
   always_ff @(posedge clk) begin
      if (reset) begin
         cc_q     <= CC_RESET;
         fn_err_q <= 1'b0;
         cnt_q    <= {CNT_W{1'b0}};
      end else begin
         cc_q     <= cc_d;
         fn_err_q <= fn_err_d;
         cnt_q    <= cnt_d;
      end
   end

   // Drive outputs: registered state plus the combinational condition.
   always_comb begin
      bus.cc_out     = cc_q;
      bus.fn_err     = fn_err_q;
      bus.cc_updates = cnt_q;
      bus.cond_out   = eval_cond(bus.cond_fn, flags_eff_s);
   end

endmodule

// File: tb/tb_alu_cc_unit.sv
// Scoreboard bench for alu_cc_unit. A 16-bit-counter instance and a 2-bit
// counter instance share the same stimulus; expected values are queued by the
// stimulus process and checked by a separate monitor on the falling edge.
module tb_alu_cc_unit;

`ifdef ALU_CC_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      string      name;
      logic [2:0] cc;
      logic       cond;
      logic       err;
      int         cnt;
      int         cnt2;
   } exp_t;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   exp_t sb_q[$];

   alu_cc_unit_if #(.CNT_W(16)) bus16 ();
   alu_cc_unit_if #(.CNT_W(2))  bus2 ();

   assign bus2.set_cc     = bus16.set_cc;
   assign bus2.stall      = bus16.stall;
   assign bus2.exc_block  = bus16.exc_block;
   assign bus2.alu_fn     = bus16.alu_fn;
   assign bus2.alu_result = bus16.alu_result;
   assign bus2.alu_ovf    = bus16.alu_ovf;
   assign bus2.cond_fn    = bus16.cond_fn;

   alu_cc_unit #(.CNT_W(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16.slave));
   alu_cc_unit #(.CNT_W(2))  dut2  (.clk(clk), .reset(reset), .bus(bus2.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: one expectation per cycle, compared mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         checks = checks + 1;
         if (bus16.cc_out !== e.cc) begin
            errors = errors + 1;
            $display("FAIL %s cc_out got %b want %b", e.name, bus16.cc_out, e.cc);
         end
         checks = checks + 1;
         if (bus16.cond_out !== e.cond) begin
            errors = errors + 1;
            $display("FAIL %s cond_out got %b want %b", e.name, bus16.cond_out, e.cond);
         end
         checks = checks + 1;
         if (bus16.fn_err !== e.err) begin
            errors = errors + 1;
            $display("FAIL %s fn_err got %b want %b", e.name, bus16.fn_err, e.err);
         end
         checks = checks + 1;
         if (bus16.cc_updates !== 16'(e.cnt)) begin
            errors = errors + 1;
            $display("FAIL %s cc_updates got %0d want %0d", e.name, bus16.cc_updates, e.cnt);
         end
         checks = checks + 1;
         if (bus2.cc_updates !== 2'(e.cnt2)) begin
            errors = errors + 1;
            $display("FAIL %s cc_updates_w2 got %0d want %0d", e.name, bus2.cc_updates, e.cnt2);
         end
      end
   end

   task automatic drive(input logic s, input logic st, input logic ex, input logic [3:0] fn,
                        input logic [63:0] res, input logic ovf, input logic [3:0] cf);
      bus16.set_cc     = s;
      bus16.stall      = st;
      bus16.exc_block  = ex;
      bus16.alu_fn     = fn;
      bus16.alu_result = res;
      bus16.alu_ovf    = ovf;
      bus16.cond_fn    = cf;
   endtask

   task automatic step(input logic s, input logic st, input logic ex, input logic [3:0] fn,
                       input logic [63:0] res, input logic ovf, input logic [3:0] cf,
                       input string nm, input logic [2:0] ecc, input logic ecnd,
                       input logic eerr, input int ecnt);
      exp_t e;
      @(posedge clk);
      #1;
      drive(s, st, ex, fn, res, ovf, cf);
      e.name = nm;
      e.cc   = ecc;
      e.cond = ecnd;
      e.err  = eerr;
      e.cnt  = ecnt;
      e.cnt2 = (ecnt > 3) ? 3 : ecnt;
      sb_q.push_back(e);
   endtask

   task automatic idle(input logic [3:0] cf, input string nm, input logic [2:0] ecc,
                       input logic ecnd, input logic eerr, input int ecnt);
      step(1'b0, 1'b0, 1'b0, 4'd0, 64'd0, 1'b0, cf, nm, ecc, ecnd, eerr, ecnt);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 4'd0, 64'd0, 1'b0, 4'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Watchdog in case the clock or queue drain never completes.
   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   // Directed stimulus with hand-computed expectations.
   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 4'd0, 64'd0, 1'b0, 4'd0);
      do_reset();

      idle(4'd3, "rst_e", 3'b100, 1'b1, 1'b0, 0);
      idle(4'd4, "rst_ne", 3'b100, 1'b0, 1'b0, 0);

      step(1'b1, 1'b0, 1'b0, 4'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 4'd6,
           "add_same_cyc_g", 3'b100, BYP, 1'b0, 0);
      idle(4'd6, "add_g", 3'b011, 1'b1, 1'b0, 1);
      idle(4'd2, "add_l", 3'b011, 1'b0, 1'b0, 1);
      idle(4'd1, "add_le", 3'b011, 1'b0, 1'b0, 1);

      step(1'b1, 1'b0, 1'b0, 4'd1, 64'd0, 1'b0, 4'd1,
           "sub_same_cyc_le", 3'b011, BYP, 1'b0, 1);
      idle(4'd1, "sub_le", 3'b100, 1'b1, 1'b0, 2);
      idle(4'd5, "sub_ge", 3'b100, 1'b1, 1'b0, 2);
      idle(4'd6, "sub_g", 3'b100, 1'b0, 1'b0, 2);

      step(1'b1, 1'b1, 1'b0, 4'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 4'd0,
           "stall_set", 3'b100, 1'b1, 1'b0, 2);
      idle(4'd3, "stall_hold", 3'b100, 1'b1, 1'b0, 2);

      step(1'b1, 1'b0, 1'b0, 4'd3, 64'h8000_0000_0000_0000, 1'b1, 4'd2,
           "xor_same_cyc_l", 3'b100, BYP, 1'b0, 2);
      idle(4'd2, "xor_l", 3'b010, 1'b1, 1'b0, 3);

      step(1'b1, 1'b0, 1'b1, 4'd0, 64'd0, 1'b0, 4'd3,
           "exc_set", 3'b010, 1'b0, 1'b0, 3);
      idle(4'd3, "exc_hold", 3'b010, 1'b0, 1'b0, 3);

      step(1'b1, 1'b0, 1'b0, 4'd2, 64'd1, 1'b1, 4'd0,
           "and_set", 3'b010, 1'b1, 1'b0, 3);
      idle(4'd4, "and_ne", 3'b000, 1'b1, 1'b0, 4);

      step(1'b1, 1'b0, 1'b0, 4'd7, 64'd0, 1'b0, 4'd0,
           "bad_fn_set", 3'b000, 1'b1, 1'b0, 4);
      idle(4'd9, "bad_cond", 3'b000, 1'b0, 1'b1, 4);
      idle(4'd0, "err_sticky", 3'b000, 1'b1, 1'b1, 4);
      step(1'b0, 1'b1, 1'b0, 4'd0, 64'd0, 1'b0, 4'd9,
           "err_sticky_stall", 3'b000, 1'b0, 1'b1, 4);

      do_reset();
      idle(4'd3, "rst2_e", 3'b100, 1'b1, 1'b0, 0);
      step(1'b0, 1'b1, 1'b0, 4'd0, 64'd0, 1'b0, 4'd9,
           "stall_bad_cond", 3'b100, 1'b0, 1'b0, 0);
      idle(4'd0, "stall_no_err", 3'b100, 1'b1, 1'b0, 0);

      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 1'b0, 4'd0, 64'd5, 1'b0, 4'd0, $sformatf("b2b_%0d", i),
              (i == 0) ? 3'b100 : 3'b000, 1'b1, 1'b0, i);
      end
      idle(4'd4, "b2b_sat", 3'b000, 1'b1, 1'b0, 4);

      @(posedge clk);
      #1;
      reset = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 4'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 4'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 4'd0, 64'd0, 1'b0, 4'd0);
      idle(4'd3, "rst_discard", 3'b100, 1'b1, 1'b0, 0);

      for (int i = 0; i < 20 && sb_q.size() > 0; i++) begin
         @(posedge clk);
      end
      if (sb_q.size() > 0) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL drain pending %0d want 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
